sevenseg_display: RTL and testbench

SEVENSEG_DISPLAY -- requirements
Module: sevenseg_display

---
 rtl/sevenseg_display.sv | 222 ++++++++++++++++++++++
 tb/tb_sevenseg_display.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_display.sv
// sevenseg_display: eight-digit multiplexed seven-segment driver fed by a
// small write FIFO. Each accepted 32-bit word is shown for at least
// HOLD_CYCLES clocks; digits are scanned one at a time, REFRESH_DIV clocks
// per digit, with registered active-low cathode and anode outputs.
// Optional build macro: SEVENSEG_BLANK_EN -- blank leading-zero digits
// (segments all off) above the most significant non-zero nibble.
module sevenseg_display #(
    parameter int unsigned REFRESH_DIV = 1024,
    parameter int unsigned HOLD_CYCLES = 4096,
    parameter int unsigned DEPTH       = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sevenseg_writeEnable,
    input  logic [31:0] sevenseg_data,
    output logic [7:0]  segments,
    output logic [7:0]  enables,
    output logic [31:0] shown_word,
    output logic        fifo_full,
    output logic        overflow
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned REF_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [AW:0]       DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    // Display FSM encodings
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]       r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_overflow;

    logic [0:0]        r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [31:0]       r_shown_word;

    logic [REF_W-1:0]  r_refresh_cnt;
    logic [2:0]        r_digit;
    logic [7:0]        r_segments;
    logic [7:0]        r_enables;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [31:0]       w_head;
    logic [31:0]       w_shown_next;
    logic              w_refresh_wrap;
    logic [REF_W-1:0]  w_refresh_next;
    logic [2:0]        w_digit_next;
    logic [3:0]        w_nibble;
    logic [7:0]        w_seg_next;
`ifdef SEVENSEG_BLANK_EN
    logic [2:0]        w_msd;
`endif

    // Hex digit to active-low {DP,G,F,E,D,C,B,A}; DP always off.
    function automatic logic [7:0] f_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    // FIFO status, pop/push arbitration. Only the display FSM pops; a push
    // into a full FIFO is still taken when a pop frees the slot that edge.
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == DEPTH_CNT);
        w_head  = r_mem[r_rd_ptr];
        w_pop   = 1'b0;
        if (!w_empty) begin
            if (r_state == ST_EMPTY)
                w_pop = 1'b1;
            else if (r_hold_cnt == '0)
                w_pop = 1'b1;
        end
        w_push = sevenseg_writeEnable && (!w_full || w_pop);
        w_drop = sevenseg_writeEnable && !w_push;
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= sevenseg_data;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Display FSM: latch a word, hold it for HOLD_CYCLES, then take the next.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_EMPTY;
            r_hold_cnt   <= '0;
            r_shown_word <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (!w_empty) begin
                        r_shown_word <= w_head;
                        r_hold_cnt   <= HOLD_LOAD;
                        r_state      <= ST_HOLD;
                    end
                end
                default: begin
                    if (r_hold_cnt != '0) begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end else if (!w_empty) begin
                        r_shown_word <= w_head;
                        r_hold_cnt   <= HOLD_LOAD;
                    end else begin
                        r_state <= ST_EMPTY;
                    end
                end
            endcase
        end
    end

    // Next-state view of scan position and displayed word. The output
    // registers are loaded from these so that segments/enables always
    // match the current digit and shown_word with no extra pipeline lag.
    always_comb begin
        w_shown_next   = w_pop ? w_head : r_shown_word;
        w_refresh_wrap = (r_refresh_cnt == REF_LAST);
        w_refresh_next = w_refresh_wrap ? '0 : r_refresh_cnt + REF_W'(1);
        w_digit_next   = w_refresh_wrap ? r_digit + 3'd1 : r_digit;
        w_nibble       = w_shown_next[{w_digit_next, 2'b00} +: 4];
`ifdef SEVENSEG_BLANK_EN
        w_msd = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (w_shown_next[4*i +: 4] != 4'h0)
                w_msd = 3'(i);
        end
        w_seg_next = (w_digit_next > w_msd) ? 8'hFF : f_decode(w_nibble);
`else
        w_seg_next = f_decode(w_nibble);
`endif
    end

    // Free-running digit scan, independent of FSM and FIFO activity.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_refresh_cnt <= '0;
            r_digit       <= '0;
        end else begin
            r_refresh_cnt <= w_refresh_next;
            r_digit       <= w_digit_next;
        end
    end

    // Registered pin drivers for glitch-free cathodes and anodes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_segments <= 8'hC0;
            r_enables  <= 8'hFE;
        end else begin
            r_segments <= w_seg_next;
            r_enables  <= ~(8'b1 << w_digit_next);
        end
    end

    assign segments   = r_segments;
    assign enables    = r_enables;
    assign shown_word = r_shown_word;
    assign fifo_full  = w_full;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_sevenseg_display.sv
// tb_sevenseg_display: directed bench for sevenseg_display with
// REFRESH_DIV=4, HOLD_CYCLES=8, DEPTH=4. Honours SEVENSEG_BLANK_EN.
module tb_sevenseg_display;

    logic        clock;
    logic        reset;
    logic        sevenseg_writeEnable;
    logic [31:0] sevenseg_data;
    logic [7:0]  segments;
    logic [7:0]  enables;
    logic [31:0] shown_word;
    logic        fifo_full;
    logic        overflow;

    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned edge_no;

    sevenseg_display #(
        .REFRESH_DIV(4),
        .HOLD_CYCLES(8),
        .DEPTH(4)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .sevenseg_writeEnable(sevenseg_writeEnable),
        .sevenseg_data       (sevenseg_data),
        .segments            (segments),
        .enables             (enables),
        .shown_word          (shown_word),
        .fifo_full           (fifo_full),
        .overflow            (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    // One rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clock);
        #1;
        edge_no++;
    endtask

    task automatic run_to(input int unsigned target);
        while (edge_no < target) tick();
    endtask

    // Reset over a few edges; release 1 unit after an edge so edge 1 is next.
    task automatic do_reset();
        sevenseg_writeEnable = 1'b0;
        sevenseg_data        = '0;
        reset                = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset   = 1'b0;
        edge_no = 0;
    endtask

    // Write one word per edge on edges edge_no+1 .. edge_no+n.
    task automatic write_seq(input logic [31:0] base, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            sevenseg_writeEnable = 1'b1;
            sevenseg_data        = base + 32'(i);
            tick();
        end
        sevenseg_writeEnable = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        edge_no  = 0;
        reset    = 1'b1;
        sevenseg_writeEnable = 1'b0;
        sevenseg_data        = '0;

        // ---------------- Reset state and basic display ----------------
        do_reset();
        check("rst_enables",  32'(enables),   32'hFE);
        check("rst_segments", 32'(segments),  32'hC0);
        check("rst_shown",    shown_word,     32'h0);
        check("rst_overflow", 32'(overflow),  32'h0);
        check("rst_full",     32'(fifo_full), 32'h0);

        write_seq(32'h12345678, 1);                       // edge 1
        check("lat_not_yet", shown_word, 32'h0);
        tick();                                           // edge 2
        check("lat_shown",   shown_word,     32'h12345678);
        check("d0_enables",  32'(enables),   32'hFE);
        check("d0_segments", 32'(segments),  32'h80);
        run_to(4);
        check("d1_enables",  32'(enables),   32'hFD);
        check("d1_segments", 32'(segments),  32'hF8);
        run_to(8);
        check("d2_enables",  32'(enables),   32'hFB);
        check("d2_segments", 32'(segments),  32'h82);
        run_to(28);
        check("d7_enables",  32'(enables),   32'h7F);
        check("d7_segments", 32'(segments),  32'hF9);
        check("hold_retain", shown_word,     32'h12345678);
        run_to(32);
        check("wrap_enables",  32'(enables),  32'hFE);
        check("wrap_segments", 32'(segments), 32'h80);

        // ---------------- Overflow and ordering ----------------
        do_reset();
        write_seq(32'h1, 5);                              // edges 1..5
        check("ovf_full5",   32'(fifo_full), 32'h1);
        check("ovf_none5",   32'(overflow),  32'h0);
        check("ovf_shown1",  shown_word,     32'h1);
        write_seq(32'h6, 1);                              // edge 6, dropped
        check("ovf_set",     32'(overflow),  32'h1);
        check("ovf_full6",   32'(fifo_full), 32'h1);
        run_to(9);
        check("ovf_still1",  shown_word,     32'h1);
        run_to(10);
        check("ovf_shown2",  shown_word,     32'h2);
        check("ovf_notfull", 32'(fifo_full), 32'h0);
        run_to(17);
        check("ovf_still2",  shown_word,     32'h2);
        run_to(18);
        check("ovf_shown3",  shown_word,     32'h3);
        run_to(26);
        check("ovf_shown4",  shown_word,     32'h4);
        run_to(34);
        check("ovf_shown5",  shown_word,     32'h5);
        run_to(60);
        check("ovf_final5",  shown_word,     32'h5);
        check("ovf_sticky",  32'(overflow),  32'h1);
        check("ovf_dig_seg", 32'(segments),  (enables == 8'hFE) ? 32'h92 :
`ifdef SEVENSEG_BLANK_EN
                                             32'hFF);
`else
                                             32'hC0);
`endif

        // ---------------- Push while full on the pop edge ----------------
        do_reset();
        write_seq(32'h100, 5);                            // edges 1..5, full
        run_to(9);
        check("pp_full_pre", 32'(fifo_full), 32'h1);
        write_seq(32'h105, 1);                            // edge 10, pop+push
        check("pp_full",     32'(fifo_full), 32'h1);
        check("pp_no_ovf",   32'(overflow),  32'h0);
        check("pp_shown",    shown_word,     32'h101);
        run_to(42);
        check("pp_last",     shown_word,     32'h105);

        // ---------------- Leading-zero handling ----------------
        do_reset();
        write_seq(32'h000000A5, 1);                       // edge 1
        run_to(3);
        check("blk_d0", 32'(segments), 32'h92);
        run_to(4);
        check("blk_d1", 32'(segments), 32'h88);
        run_to(8);
        check("blk_d2_en", 32'(enables), 32'hFB);
`ifdef SEVENSEG_BLANK_EN
        check("blk_d2", 32'(segments), 32'hFF);
        run_to(28);
        check("blk_d7", 32'(segments), 32'hFF);
`else
        check("blk_d2", 32'(segments), 32'hC0);
        run_to(28);
        check("blk_d7", 32'(segments), 32'hC0);
`endif
        check("blk_d7_en", 32'(enables), 32'h7F);

        // ---------------- Asynchronous reset mid-HOLD ----------------
        do_reset();
        write_seq(32'hAAAA0001, 3);                       // edges 1..3
        run_to(5);
        check("ar_pre_shown", shown_word, 32'hAAAA0001);
        #2;
        reset = 1'b1;
        #1;
        check("ar_shown",    shown_word,     32'h0);
        check("ar_enables",  32'(enables),   32'hFE);
        check("ar_segments", 32'(segments),  32'hC0);
        check("ar_full",     32'(fifo_full), 32'h0);
        check("ar_overflow", 32'(overflow),  32'h0);
        @(posedge clock);
        #1;
        reset   = 1'b0;
        edge_no = 0;
        run_to(30);
        check("ar_never_shown", shown_word,    32'h0);
        check("ar_empty_full",  32'(fifo_full), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
